mouse_init_ctrl: RTL and testbench
==================================

MOUSE_INIT_CTRL -- requirements
Module: mouse_init_ctrl

Interface
REQ-001 Parameter RESP_TIMEOUT, 50_000_000, max clk cycles waiting for any device response byte.
REQ-002 Parameter PKT_GAP, 200_000, max clk cycles between bytes inside one stream packet.
REQ-003 Parameter MAX_RETRY, 3, init attempts allowed before entering ERROR.
REQ-004 Parameter SAMPLE_RATE, 8'd100, rate byte sent when MOUSE_RATE_CMD_EN is defined.
REQ-005 Port list: clk in 1 system clock; rst in 1 reset, asynchronous, active-high; txData out 8 command byte; txStart out 1 one-cycle transmit request; txBusy in 1 transmitter busy; txDone in 1 one-cycle byte-sent pulse; txErr in 1 one-cycle transmit-failure pulse; rxReady in 1 one-cycle received-byte pulse; rxData in 8 received byte; mouseReady out 1 one-cycle forwarded-byte strobe; mouseData out 8 forwarded byte; decoderRst out 1 one-cycle decoder resync pulse; initDone out 1 STREAM reached; initError out 1 ERROR reached; retryCount out 2 failed attempts so far; ctrlState out 4 current state code.

Function
REQ-006 States/codes: SEND_RST 0, WAIT_ACK_RST 1, WAIT_BAT 2, WAIT_ID 3, SEND_RATE 4, WAIT_ACK_RATE 5, SEND_RATE_VAL 6, WAIT_ACK_VAL 7, SEND_EN 8, WAIT_ACK_EN 9, STREAM 10, ERROR 11; ctrlState shall equal the code.
REQ-007 SEND_* states shall present the byte (FF, F3, SAMPLE_RATE, F4 respectively) on txData and pulse txStart exactly once, in the first cycle with txBusy=0.
REQ-008 SEND_* shall advance to its WAIT_* successor on txDone; txErr shall count as a failed attempt.
REQ-009 WAIT_ACK_* shall advance on rxReady with rxData=FA; WAIT_BAT expects AA; WAIT_ID expects 00.
REQ-010 rxData=FE in any WAIT_ACK_* shall return to the preceding SEND_* (resend) without counting a failure.
REQ-011 Failed attempt = timeout, txErr, or any other unexpected byte in init states; shall increment retryCount and return to SEND_RST.
REQ-012 When retryCount would reach MAX_RETRY, shall enter ERROR instead; ERROR is terminal until rst.
REQ-013 Response timer shall clear on every state entry and on every rxReady; reaching RESP_TIMEOUT in a WAIT_* state is a timeout.
REQ-014 After WAIT_ID: next state SEND_RATE if MOUSE_RATE_CMD_EN defined, else SEND_EN.
REQ-015 initDone shall be 1 exactly while in STREAM; initError exactly while in ERROR.
REQ-016 mouseReady shall never pulse outside STREAM; init-phase bytes shall not be forwarded.
REQ-017 STREAM shall track packet byte index 0..2, wrapping 2->0.
REQ-018 Byte at index 0 with rxData[3]=0 shall be dropped (no mouseReady), index stays 0.
REQ-019 Accepted byte: mouseData<=rxData and mouseReady=1 on the cycle after rxReady (1-cycle latency), mouseData held until next accepted byte.
REQ-020 Gap timer in STREAM shall clear on rxReady; if index≠0 and gap reaches PKT_GAP, decoderRst shall pulse one cycle and index shall return to 0.
REQ-021 decoderRst shall also pulse one cycle on entry to STREAM.
REQ-022 rxReady and timeout in the same cycle: rxReady wins.
REQ-023 The module shall only sequence; it shall not interpret movement or button bits.

Reset
REQ-024 rst asserted shall immediately force state SEND_RST, txStart=0, txData=00, mouseReady=0, mouseData=00, decoderRst=0, initDone=0, initError=0, retryCount=0, timers and index=0.
REQ-025 rst mid-transmission or mid-packet shall abandon it; after release the sequence restarts with a fresh FF.

Configuration
REQ-026 Macro MOUSE_RATE_CMD_EN: defined -> F3, SAMPLE_RATE inserted between WAIT_ID and SEND_EN; undefined -> states 4-7 unreachable, WAIT_ID goes directly to SEND_EN; all else identical.

Verification
REQ-027 Clean init, macro off: device replies FA, AA, 00, FA -> txData sequence FF, F4; initDone=1; decoderRst one pulse; retryCount=0.
REQ-028 Macro on: same replies plus FA, FA -> txData sequence FF, F3, 64, F4; initDone=1.
REQ-029 FE after F4 -> F4 resent once, retryCount stays 0, then FA -> STREAM.
REQ-030 No reply to FF three times (RESP_TIMEOUT each) -> retryCount 1,2 then ERROR, initError=1, no further txStart.
REQ-031 STREAM bytes 08,05,FE -> three mouseReady pulses with those data; byte 00 at index 0 -> dropped.
REQ-032 STREAM bytes 08,05 then silence PKT_GAP -> decoderRst pulse, next byte 09 treated as index 0 and forwarded.

Source files
------------

// File: rtl/mouse_init_ctrl.sv
// mouse_init_ctrl: sequences PS/2 mouse initialisation (reset, optional sample
// rate, enable streaming) with retries and timeouts. In STREAM it forwards the
// bytes of each 3-byte packet and resynchronises the downstream decoder when a
// packet stalls.
// Optional feature: define MOUSE_RATE_CMD_EN to insert the F3 / SAMPLE_RATE
// exchange between the ID byte and the enable command.
module mouse_init_ctrl #(
    parameter int         RESP_TIMEOUT = 50_000_000,
    parameter int         PKT_GAP      = 200_000,
    parameter int         MAX_RETRY    = 3,
    parameter logic [7:0] SAMPLE_RATE  = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] txData,
    output logic       txStart,
    input  logic       txBusy,
    input  logic       txDone,
    input  logic       txErr,
    input  logic       rxReady,
    input  logic [7:0] rxData,
    output logic       mouseReady,
    output logic [7:0] mouseData,
    output logic       decoderRst,
    output logic       initDone,
    output logic       initError,
    output logic [1:0] retryCount,
    output logic [3:0] ctrlState
);

    localparam int RESP_W = $clog2(RESP_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(PKT_GAP + 1);

    localparam logic [RESP_W-1:0] RESP_LAST = RESP_W'(RESP_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(PKT_GAP - 1);

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
    localparam logic [7:0] BYTE_ID     = 8'h00;

    typedef enum logic [3:0] {
        SEND_RST      = 4'd0,
        WAIT_ACK_RST  = 4'd1,
        WAIT_BAT      = 4'd2,
        WAIT_ID       = 4'd3,
        SEND_RATE     = 4'd4,
        WAIT_ACK_RATE = 4'd5,
        SEND_RATE_VAL = 4'd6,
        WAIT_ACK_VAL  = 4'd7,
        SEND_EN       = 4'd8,
        WAIT_ACK_EN   = 4'd9,
        STREAM        = 4'd10,
        ERROR         = 4'd11
    } state_e;

    // Command byte transmitted by each SEND_* state.
    function automatic logic [7:0] cmd_byte(input state_e s);
        case (s)
            SEND_RST:      cmd_byte = 8'hFF;
            SEND_RATE:     cmd_byte = 8'hF3;
            SEND_RATE_VAL: cmd_byte = SAMPLE_RATE;
            SEND_EN:       cmd_byte = 8'hF4;
            default:       cmd_byte = 8'h00;
        endcase
    endfunction

    // WAIT_ACK_* state that follows a successful transmit.
    function automatic state_e wait_of(input state_e s);
        case (s)
            SEND_RST:      wait_of = WAIT_ACK_RST;
            SEND_RATE:     wait_of = WAIT_ACK_RATE;
            SEND_RATE_VAL: wait_of = WAIT_ACK_VAL;
            SEND_EN:       wait_of = WAIT_ACK_EN;
            default:       wait_of = SEND_RST;
        endcase
    endfunction

    // SEND_* state to go back to when the device asks for a resend.
    function automatic state_e resend_of(input state_e s);
        case (s)
            WAIT_ACK_RST:  resend_of = SEND_RST;
            WAIT_ACK_RATE: resend_of = SEND_RATE;
            WAIT_ACK_VAL:  resend_of = SEND_RATE_VAL;
            WAIT_ACK_EN:   resend_of = SEND_EN;
            default:       resend_of = SEND_RST;
        endcase
    endfunction

    // State reached once a WAIT_ACK_* sees the acknowledge byte.
    function automatic state_e ack_next(input state_e s);
        case (s)
            WAIT_ACK_RST:  ack_next = WAIT_BAT;
            WAIT_ACK_RATE: ack_next = SEND_RATE_VAL;
            WAIT_ACK_VAL:  ack_next = SEND_EN;
            WAIT_ACK_EN:   ack_next = STREAM;
            default:       ack_next = SEND_RST;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic              sent_q, sent_d;
    logic [RESP_W-1:0] resp_cnt_q, resp_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        retry_q, retry_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              mouse_ready_q, mouse_ready_d;
    logic [7:0]        mouse_data_q, mouse_data_d;
    logic              dec_rst_q, dec_rst_d;
    logic              init_done_q, init_done_d;
    logic              init_error_q, init_error_d;

    logic              enter_s;
    logic              fail_s;
    logic              resp_expired_s;

    // Next-state, timer, packet-index and output decode.
    always_comb begin
        state_d        = state_q;
        sent_d         = sent_q;
        resp_cnt_d     = resp_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        idx_d          = idx_q;
        retry_d        = retry_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        mouse_ready_d  = 1'b0;
        mouse_data_d   = mouse_data_q;
        dec_rst_d      = 1'b0;
        enter_s        = 1'b0;
        fail_s         = 1'b0;
        resp_expired_s = (resp_cnt_q >= RESP_LAST);

        case (state_q)
            SEND_RST, SEND_RATE, SEND_RATE_VAL, SEND_EN: begin
                tx_data_d = cmd_byte(state_q);
                // one request per visit, issued as soon as the line is free
                if (!sent_q && !txBusy) begin
                    tx_start_d = 1'b1;
                    sent_d     = 1'b1;
                end else begin
                    tx_start_d = 1'b0;
                end
                if (sent_q && txErr) begin
                    fail_s = 1'b1;
                end else if (sent_q && txDone) begin
                    state_d = wait_of(state_q);
                    enter_s = 1'b1;
                end else if (rxReady) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end

            WAIT_ACK_RST, WAIT_ACK_RATE, WAIT_ACK_VAL, WAIT_ACK_EN: begin
                // a received byte takes priority over a simultaneous timeout
                if (rxReady) begin
                    if (rxData == BYTE_ACK) begin
                        state_d = ack_next(state_q);
                        enter_s = 1'b1;
                    end else if (rxData == BYTE_RESEND) begin
                        state_d = resend_of(state_q);
                        enter_s = 1'b1;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else if (resp_expired_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end

            WAIT_BAT: begin
                if (rxReady) begin
                    if (rxData == BYTE_BAT_OK) begin
                        state_d = WAIT_ID;
                        enter_s = 1'b1;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else if (resp_expired_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end

            WAIT_ID: begin
                if (rxReady) begin
                    if (rxData == BYTE_ID) begin
`ifdef MOUSE_RATE_CMD_EN
                        state_d = SEND_RATE;
`else
                        state_d = SEND_EN;
`endif
                        enter_s = 1'b1;
                    end else begin
                        fail_s = 1'b1;
                    end
                end else if (resp_expired_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end

            STREAM: begin
                if (rxReady) begin
                    gap_cnt_d = '0;
                    // a first byte without the always-one bit is out of sync
                    if ((idx_q == 2'd0) && !rxData[3]) begin
                        idx_d = 2'd0;
                    end else begin
                        mouse_ready_d = 1'b1;
                        mouse_data_d  = rxData;
                        idx_d         = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
                    end
                end else if (idx_q != 2'd0) begin
                    if (gap_cnt_q >= GAP_LAST) begin
                        dec_rst_d = 1'b1;
                        idx_d     = 2'd0;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end else begin
                    gap_cnt_d = '0;
                end
            end

            ERROR: begin
                state_d = ERROR;
            end

            default: begin
                state_d = SEND_RST;
                enter_s = 1'b1;
            end
        endcase

        // failed attempt: retry from the reset command or give up
        if (fail_s) begin
            enter_s = 1'b1;
            if (({30'd0, retry_q} + 32'd1) >= 32'(MAX_RETRY)) begin
                state_d = ERROR;
            end else begin
                retry_d = retry_q + 2'd1;
                state_d = SEND_RST;
            end
        end else begin
            retry_d = retry_q;
        end

        if (enter_s || rxReady) begin
            resp_cnt_d = '0;
        end else if (!resp_expired_s) begin
            resp_cnt_d = resp_cnt_q + RESP_W'(1);
        end else begin
            resp_cnt_d = resp_cnt_q;
        end

        // every state entry starts with a fresh transmit flag and packet
        if (enter_s) begin
            sent_d     = 1'b0;
            tx_start_d = 1'b0;
            idx_d      = 2'd0;
            gap_cnt_d  = '0;
            dec_rst_d  = (state_d == STREAM);
        end else begin
            sent_d = sent_d;
        end

        init_done_d  = (state_d == STREAM);
        init_error_d = (state_d == ERROR);
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SEND_RST;
            sent_q        <= 1'b0;
            resp_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            idx_q         <= 2'd0;
            retry_q       <= 2'd0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            mouse_ready_q <= 1'b0;
            mouse_data_q  <= 8'h00;
            dec_rst_q     <= 1'b0;
            init_done_q   <= 1'b0;
            init_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sent_q        <= sent_d;
            resp_cnt_q    <= resp_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            mouse_ready_q <= mouse_ready_d;
            mouse_data_q  <= mouse_data_d;
            dec_rst_q     <= dec_rst_d;
            init_done_q   <= init_done_d;
            init_error_q  <= init_error_d;
        end
    end

    assign txData     = tx_data_q;
    assign txStart    = tx_start_q;
    assign mouseReady = mouse_ready_q;
    assign mouseData  = mouse_data_q;
    assign decoderRst = dec_rst_q;
    assign initDone   = init_done_q;
    assign initError  = init_error_q;
    assign retryCount = retry_q;
    assign ctrlState  = state_q;

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// Directed testbench for mouse_init_ctrl with shortened timeouts.
module tb_mouse_init_ctrl;

    localparam int RT = 60;
    localparam int PG = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] txData;
    logic       txStart;
    logic       txBusy = 1'b0;
    logic       txDone = 1'b0;
    logic       txErr = 1'b0;
    logic       rxReady = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       mouseReady;
    logic [7:0] mouseData;
    logic       decoderRst;
    logic       initDone;
    logic       initError;
    logic [1:0] retryCount;
    logic [3:0] ctrlState;

    int n_checks = 0;
    int n_pass   = 0;
    int tx_cnt   = 0;
    int mr_cnt   = 0;
    int dec_cnt  = 0;

`ifdef MOUSE_RATE_CMD_EN
    localparam int INIT_TX = 4;
`else
    localparam int INIT_TX = 2;
`endif

    mouse_init_ctrl #(
        .RESP_TIMEOUT(RT),
        .PKT_GAP(PG),
        .MAX_RETRY(3),
        .SAMPLE_RATE(8'd100)
    ) dut (
        .clk(clk), .rst(rst),
        .txData(txData), .txStart(txStart), .txBusy(txBusy),
        .txDone(txDone), .txErr(txErr),
        .rxReady(rxReady), .rxData(rxData),
        .mouseReady(mouseReady), .mouseData(mouseData),
        .decoderRst(decoderRst), .initDone(initDone), .initError(initError),
        .retryCount(retryCount), .ctrlState(ctrlState)
    );

    always #5 clk = ~clk;

    // pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (txStart === 1'b1) tx_cnt++;
        if (mouseReady === 1'b1) mr_cnt++;
        if (decoderRst === 1'b1) dec_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_tx(input int limit, output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txStart === 1'b1) begin
                d  = txData;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rx_pulse(input logic [7:0] b, output logic mr, output logic [7:0] md);
        @(negedge clk);
        rxReady = 1'b1;
        rxData  = b;
        @(negedge clk);
        mr = mouseReady;
        md = mouseData;
        rxReady = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; txDone = 1'b0; txErr = 1'b0; rxReady = 1'b0; txBusy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // wait for one command, compare its byte, then report it as sent
    task automatic serve_cmd(input logic [7:0] exp);
        logic [7:0] d;
        bit ok;
        wait_tx(40, d, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL cmd_start: no txStart seen, expected byte %02h", exp);
        else n_pass++;
        n_checks++;
        if (d !== exp) $display("FAIL cmd_byte: txData=%02h expected %02h", d, exp);
        else n_pass++;
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
    endtask

    task automatic run_init(input bit fe_on_en);
        logic mr;
        logic [7:0] md;
        serve_cmd(8'hFF);
        rx_pulse(8'hFA, mr, md);
        rx_pulse(8'hAA, mr, md);
        rx_pulse(8'h00, mr, md);
`ifdef MOUSE_RATE_CMD_EN
        serve_cmd(8'hF3);
        rx_pulse(8'hFA, mr, md);
        serve_cmd(8'h64);
        rx_pulse(8'hFA, mr, md);
`endif
        serve_cmd(8'hF4);
        if (fe_on_en) begin
            rx_pulse(8'hFE, mr, md);
            serve_cmd(8'hF4);
        end
        rx_pulse(8'hFA, mr, md);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (ctrlState !== 4'd0) $display("FAIL rst_state: %0d expected 0", ctrlState); else n_pass++;
        n_checks++; if (txStart !== 1'b0) $display("FAIL rst_txstart: %b expected 0", txStart); else n_pass++;
        n_checks++; if (txData !== 8'h00) $display("FAIL rst_txdata: %02h expected 00", txData); else n_pass++;
        n_checks++; if (mouseReady !== 1'b0 || mouseData !== 8'h00) $display("FAIL rst_mouse: %b/%02h expected 0/00", mouseReady, mouseData); else n_pass++;
        n_checks++; if (decoderRst !== 1'b0 || initDone !== 1'b0 || initError !== 1'b0) $display("FAIL rst_flags: %b%b%b expected 000", decoderRst, initDone, initError); else n_pass++;
        n_checks++; if (retryCount !== 2'd0) $display("FAIL rst_retry: %0d expected 0", retryCount); else n_pass++;
        // keep the transmitter busy: no request may be issued
        txBusy = 1'b1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (tx_cnt !== 0) $display("FAIL busy_hold: %0d txStart pulses expected 0", tx_cnt); else n_pass++;
        txBusy = 1'b0;
    endtask

    task automatic test_clean_init();
        int tx0, dec0;
        tx0 = tx_cnt; dec0 = dec_cnt;
        run_init(1'b0);
        n_checks++; if (initDone !== 1'b1) $display("FAIL init_done: %b expected 1", initDone); else n_pass++;
        n_checks++; if (ctrlState !== 4'd10) $display("FAIL init_state: %0d expected 10", ctrlState); else n_pass++;
        n_checks++; if (retryCount !== 2'd0) $display("FAIL init_retry: %0d expected 0", retryCount); else n_pass++;
        n_checks++; if (dec_cnt - dec0 !== 1) $display("FAIL init_decrst: %0d pulses expected 1", dec_cnt - dec0); else n_pass++;
        n_checks++; if (tx_cnt - tx0 !== INIT_TX) $display("FAIL init_txcount: %0d expected %0d", tx_cnt - tx0, INIT_TX); else n_pass++;
        n_checks++; if (mr_cnt !== 0) $display("FAIL init_forward: %0d bytes forwarded expected 0", mr_cnt); else n_pass++;
    endtask

    task automatic test_stream();
        logic mr;
        logic [7:0] md;
        int mr0;
        mr0 = mr_cnt;
        rx_pulse(8'h08, mr, md);
        n_checks++; if (mr !== 1'b1 || md !== 8'h08) $display("FAIL stream_b0: %b/%02h expected 1/08", mr, md); else n_pass++;
        rx_pulse(8'h05, mr, md);
        n_checks++; if (mr !== 1'b1 || md !== 8'h05) $display("FAIL stream_b1: %b/%02h expected 1/05", mr, md); else n_pass++;
        rx_pulse(8'hFE, mr, md);
        n_checks++; if (mr !== 1'b1 || md !== 8'hFE) $display("FAIL stream_b2: %b/%02h expected 1/FE", mr, md); else n_pass++;
        rx_pulse(8'h00, mr, md);
        n_checks++; if (mr !== 1'b0 || md !== 8'hFE) $display("FAIL stream_drop: %b/%02h expected 0/FE", mr, md); else n_pass++;
        @(negedge clk);
        n_checks++; if (mr_cnt - mr0 !== 3) $display("FAIL stream_count: %0d expected 3", mr_cnt - mr0); else n_pass++;
    endtask

    task automatic test_gap();
        logic mr;
        logic [7:0] md;
        int dec0;
        dec0 = dec_cnt;
        rx_pulse(8'h08, mr, md);
        repeat (PG - 6) @(negedge clk);
        n_checks++; if (dec_cnt !== dec0) $display("FAIL gap_early: %0d pulses expected 0", dec_cnt - dec0); else n_pass++;
        rx_pulse(8'h05, mr, md);
        repeat (PG + 5) @(negedge clk);
        n_checks++; if (dec_cnt - dec0 !== 1) $display("FAIL gap_decrst: %0d pulses expected 1", dec_cnt - dec0); else n_pass++;
        rx_pulse(8'h09, mr, md);
        n_checks++; if (mr !== 1'b1 || md !== 8'h09) $display("FAIL gap_resync: %b/%02h expected 1/09", mr, md); else n_pass++;
        // 00 is only forwarded if 09 was taken as byte 0
        rx_pulse(8'h00, mr, md);
        n_checks++; if (mr !== 1'b1 || md !== 8'h00) $display("FAIL gap_index: %b/%02h expected 1/00", mr, md); else n_pass++;
        rx_pulse(8'h07, mr, md);
        dec0 = dec_cnt;
        repeat (PG + 5) @(negedge clk);
        n_checks++; if (dec_cnt !== dec0) $display("FAIL gap_idle: %0d pulses expected 0", dec_cnt - dec0); else n_pass++;
    endtask

    task automatic test_reset_midway();
        logic mr;
        logic [7:0] md;
        rx_pulse(8'h08, mr, md);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ctrlState !== 4'd0 || initDone !== 1'b0) $display("FAIL mid_rst_state: %0d/%b expected 0/0", ctrlState, initDone); else n_pass++;
        n_checks++; if (mouseData !== 8'h00) $display("FAIL mid_rst_data: %02h expected 00", mouseData); else n_pass++;
        rst = 1'b0;
        run_init(1'b0);
        n_checks++; if (initDone !== 1'b1) $display("FAIL mid_reinit: %b expected 1", initDone); else n_pass++;
        rx_pulse(8'h00, mr, md);
        n_checks++; if (mr !== 1'b0) $display("FAIL mid_index: mouseReady %b expected 0", mr); else n_pass++;
    endtask

    task automatic test_fe_resend();
        int tx0;
        do_reset();
        tx0 = tx_cnt;
        run_init(1'b1);
        n_checks++; if (retryCount !== 2'd0) $display("FAIL fe_retry: %0d expected 0", retryCount); else n_pass++;
        n_checks++; if (initDone !== 1'b1) $display("FAIL fe_done: %b expected 1", initDone); else n_pass++;
        n_checks++; if (tx_cnt - tx0 !== INIT_TX + 1) $display("FAIL fe_txcount: %0d expected %0d", tx_cnt - tx0, INIT_TX + 1); else n_pass++;
    endtask

    task automatic test_bad_byte();
        logic mr;
        logic [7:0] md;
        logic [7:0] d;
        bit ok;
        do_reset();
        serve_cmd(8'hFF);
        rx_pulse(8'h12, mr, md);
        wait_tx(40, d, ok);
        n_checks++; if (ok !== 1'b1 || d !== 8'hFF) $display("FAIL bad_restart: ok=%b byte=%02h expected 1/FF", ok, d); else n_pass++;
        n_checks++; if (retryCount !== 2'd1) $display("FAIL bad_retry: %0d expected 1", retryCount); else n_pass++;
        txErr = 1'b1;
        @(negedge clk);
        txErr = 1'b0;
        wait_tx(40, d, ok);
        n_checks++; if (ok !== 1'b1 || retryCount !== 2'd2) $display("FAIL txerr_retry: ok=%b retry=%0d expected 1/2", ok, retryCount); else n_pass++;
        txErr = 1'b1;
        @(negedge clk);
        txErr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (initError !== 1'b1 || ctrlState !== 4'd11) $display("FAIL txerr_error: %b/%0d expected 1/11", initError, ctrlState); else n_pass++;
    endtask

    task automatic test_timeout_error();
        logic mr;
        logic [7:0] md;
        logic [7:0] d;
        bit ok;
        int tx0;
        do_reset();
        serve_cmd(8'hFF);
        tx0 = tx_cnt;
        repeat (RT - 15) @(negedge clk);
        n_checks++; if (tx_cnt !== tx0) $display("FAIL to_early: %0d extra txStart expected 0", tx_cnt - tx0); else n_pass++;
        wait_tx(RT, d, ok);
        n_checks++; if (ok !== 1'b1 || d !== 8'hFF) $display("FAIL to_restart1: ok=%b byte=%02h expected 1/FF", ok, d); else n_pass++;
        n_checks++; if (retryCount !== 2'd1) $display("FAIL to_retry1: %0d expected 1", retryCount); else n_pass++;
        txDone = 1'b1; @(negedge clk); txDone = 1'b0;
        wait_tx(RT + 20, d, ok);
        n_checks++; if (ok !== 1'b1 || retryCount !== 2'd2) $display("FAIL to_retry2: ok=%b retry=%0d expected 1/2", ok, retryCount); else n_pass++;
        txDone = 1'b1; @(negedge clk); txDone = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < RT + 20; i++) begin
            @(negedge clk);
            if (initError === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++; if (ok !== 1'b1) $display("FAIL to_error: initError %b expected 1", initError); else n_pass++;
        n_checks++; if (ctrlState !== 4'd11 || initDone !== 1'b0) $display("FAIL to_state: %0d/%b expected 11/0", ctrlState, initDone); else n_pass++;
        n_checks++; if (retryCount !== 2'd2) $display("FAIL to_retry_hold: %0d expected 2", retryCount); else n_pass++;
        tx0 = tx_cnt;
        rx_pulse(8'hFA, mr, md);
        repeat (100) @(negedge clk);
        n_checks++; if (tx_cnt !== tx0 || ctrlState !== 4'd11) $display("FAIL to_terminal: tx=%0d state=%0d expected 0/11", tx_cnt - tx0, ctrlState); else n_pass++;
        n_checks++; if (mr_cnt !== 9) $display("FAIL no_forward_outside: %0d total forwards expected 9", mr_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_init();
        test_stream();
        test_gap();
        test_reset_midway();
        test_fe_resend();
        test_bad_byte();
        test_timeout_error();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
